// File: rtl/neuromorphic_axi_regfile_if.sv
// AXI4-Lite bus bundle for the neuromorphic register file.
// The master modport drives requests; the slave modport answers them.
interface neuromorphic_axi_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/neuromorphic_axi_regfile.sv
// AXI4-Lite slave with NUM_RW control registers followed by NUM_RO status registers.
// AW and W are held independently; a write commits once both are held and no response is pending.
module neuromorphic_axi_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RW     = 4,
    parameter int NUM_RO     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    neuromorphic_axi_regfile_if.slave    s_axi,
    output logic [NUM_RW*DATA_WIDTH-1:0] o_ctrl_regs,
    output logic [NUM_RW-1:0]            o_ctrl_wr_pulse,
    input  logic [NUM_RO*DATA_WIDTH-1:0] i_status_regs,
    output logic [NUM_RO-1:0]            o_status_rd_pulse
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);

    logic [DATA_WIDTH-1:0] r_ctrl [NUM_RW];
    logic                  r_awFull;
    logic                  r_wFull;
    logic [ADDR_WIDTH-1:0] r_awAddr;
    logic [DATA_WIDTH-1:0] r_wData;
    logic [STRB_W-1:0]     r_wStrb;
    logic                  r_bValid;
    logic [1:0]            r_bResp;
    logic [NUM_RW-1:0]     r_ctrlWrPulse;
    logic                  r_rValid;
    logic [1:0]            r_rResp;
    logic [DATA_WIDTH-1:0] r_rData;
    logic [NUM_RO-1:0]     r_statusRdPulse;

    logic                  w_awHs;
    logic                  w_wHs;
    logic                  w_arHs;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_wrIdx;
    logic [ADDR_WIDTH-1:0] w_rdIdx;
    logic [NUM_RW-1:0]     w_wrSel;
    logic [DATA_WIDTH-1:0] w_rdData;
    logic                  w_rdErr;
    logic [NUM_RO-1:0]     w_rdPulse;

    // READY outputs are forced low while reset is held and rise as soon as it drops.
    assign s_axi.S_AXI_AWREADY = !r_awFull && !rst;
    assign s_axi.S_AXI_WREADY  = !r_wFull && !rst;
    assign s_axi.S_AXI_ARREADY = !r_rValid && !rst;
    assign s_axi.S_AXI_BVALID  = r_bValid;
    assign s_axi.S_AXI_BRESP   = r_bResp;
    assign s_axi.S_AXI_RVALID  = r_rValid;
    assign s_axi.S_AXI_RRESP   = r_rResp;
    assign s_axi.S_AXI_RDATA   = r_rData;
    assign o_ctrl_wr_pulse     = r_ctrlWrPulse;
    assign o_status_rd_pulse   = r_statusRdPulse;

    assign w_awHs   = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    assign w_wHs    = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
    assign w_arHs   = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    assign w_commit = r_awFull && r_wFull && !r_bValid;
    assign w_wrIdx  = r_awAddr >> ADDR_LSB;
    assign w_rdIdx  = s_axi.S_AXI_ARADDR >> ADDR_LSB;

    for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrlOut
        assign o_ctrl_regs[g*DATA_WIDTH +: DATA_WIDTH] = r_ctrl[g];
    end

    always_comb begin
        w_wrSel = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            w_wrSel[i] = (w_wrIdx == ADDR_WIDTH'(i));
        end
    end

    // Status registers sit directly after the control registers in the word map.
    always_comb begin
        w_rdData  = '0;
        w_rdErr   = 1'b1;
        w_rdPulse = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (w_rdIdx == ADDR_WIDTH'(i)) begin
                w_rdData = r_ctrl[i];
                w_rdErr  = 1'b0;
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (w_rdIdx == ADDR_WIDTH'(NUM_RW + j)) begin
                w_rdData     = i_status_regs[j*DATA_WIDTH +: DATA_WIDTH];
                w_rdErr      = 1'b0;
                w_rdPulse[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_RW; i++) begin
                r_ctrl[i] <= '0;
            end
            r_awFull      <= 1'b0;
            r_wFull       <= 1'b0;
            r_awAddr      <= '0;
            r_wData       <= '0;
            r_wStrb       <= '0;
            r_bValid      <= 1'b0;
            r_bResp       <= 2'b00;
            r_ctrlWrPulse <= '0;
        end else begin
            if (w_awHs) begin
                r_awAddr <= s_axi.S_AXI_AWADDR;
                r_awFull <= 1'b1;
            end
            if (w_wHs) begin
                r_wData <= s_axi.S_AXI_WDATA;
                r_wStrb <= s_axi.S_AXI_WSTRB;
                r_wFull <= 1'b1;
            end
            if (w_commit) begin
                r_awFull      <= 1'b0;
                r_wFull       <= 1'b0;
                r_bValid      <= 1'b1;
                r_bResp       <= (|w_wrSel) ? 2'b00 : 2'b10;
                r_ctrlWrPulse <= w_wrSel;
                for (int i = 0; i < NUM_RW; i++) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_wrSel[i] && r_wStrb[b]) begin
                            r_ctrl[i][b*8 +: 8] <= r_wData[b*8 +: 8];
                        end
                    end
                end
            end else begin
                r_ctrlWrPulse <= '0;
                if (r_bValid && s_axi.S_AXI_BREADY) begin
                    r_bValid <= 1'b0;
                end
            end
        end
    end

    // Read data comes from r_ctrl before any same-edge commit lands, so a colliding read sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rValid        <= 1'b0;
            r_rResp         <= 2'b00;
            r_rData         <= '0;
            r_statusRdPulse <= '0;
        end else begin
            r_statusRdPulse <= '0;
            if (w_arHs) begin
                r_rValid        <= 1'b1;
                r_rData         <= w_rdData;
                r_rResp         <= w_rdErr ? 2'b10 : 2'b00;
                r_statusRdPulse <= w_rdPulse;
            end else if (r_rValid && s_axi.S_AXI_RREADY) begin
                r_rValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_neuromorphic_axi_regfile.sv
// Directed self-checking bench for neuromorphic_axi_regfile (4 control + 4 status registers, 32-bit).
module tb_neuromorphic_axi_regfile;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NRW = 4;
    localparam int NRO = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NRW*DW-1:0]  ctrlRegs;
    logic [NRW-1:0]     ctrlWrPulse;
    logic [NRO*DW-1:0]  statusRegs;
    logic [NRO-1:0]     statusRdPulse;
    int                 checks   = 0;
    int                 failures = 0;

    always #5 clk = ~clk;

    neuromorphic_axi_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    neuromorphic_axi_regfile #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RW(NRW), .NUM_RO(NRO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .s_axi             (axi.slave),
        .o_ctrl_regs       (ctrlRegs),
        .o_ctrl_wr_pulse   (ctrlWrPulse),
        .i_status_regs     (statusRegs),
        .o_status_rd_pulse (statusRdPulse)
    );

    // Presents AW and W together, waits for the response and captures BRESP and the write pulse.
    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [3:0] pulse, output bit tmo);
        bit awAcc;
        bit wAcc;
        axi.S_AXI_AWADDR  = addr;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA   = data;
        axi.S_AXI_WSTRB   = strb;
        axi.S_AXI_WVALID  = 1'b1;
        axi.S_AXI_BREADY  = 1'b0;
        tmo   = 1'b1;
        resp  = 2'b00;
        pulse = '0;
        for (int c = 0; c < 20 && (axi.S_AXI_AWVALID || axi.S_AXI_WVALID); c++) begin
            awAcc = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
            wAcc  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
            @(posedge clk); #1;
            if (awAcc) axi.S_AXI_AWVALID = 1'b0;
            if (wAcc)  axi.S_AXI_WVALID  = 1'b0;
        end
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (axi.S_AXI_BVALID) begin
                resp  = axi.S_AXI_BRESP;
                pulse = ctrlWrPulse;
                tmo   = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        if (!tmo) begin
            axi.S_AXI_BREADY = 1'b1;
            @(posedge clk); #1;
            axi.S_AXI_BREADY = 1'b0;
        end
    endtask

    // Issues one read, captures the response and the status pulse during and one cycle after RVALID.
    task automatic doRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output logic [3:0] pulse, output logic [3:0] pulseAfter, output bit tmo);
        bit arAcc;
        axi.S_AXI_ARADDR  = addr;
        axi.S_AXI_ARVALID = 1'b1;
        axi.S_AXI_RREADY  = 1'b0;
        tmo        = 1'b1;
        data       = '0;
        resp       = 2'b00;
        pulse      = '0;
        pulseAfter = '0;
        for (int c = 0; c < 20 && axi.S_AXI_ARVALID; c++) begin
            arAcc = axi.S_AXI_ARVALID && axi.S_AXI_ARREADY;
            @(posedge clk); #1;
            if (arAcc) axi.S_AXI_ARVALID = 1'b0;
        end
        axi.S_AXI_ARVALID = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (axi.S_AXI_RVALID) begin
                data  = axi.S_AXI_RDATA;
                resp  = axi.S_AXI_RRESP;
                pulse = statusRdPulse;
                tmo   = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        if (!tmo) begin
            axi.S_AXI_RREADY = 1'b1;
            @(posedge clk); #1;
            pulseAfter = statusRdPulse;
            axi.S_AXI_RREADY = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ctrlRegs !== '0) begin
            failures++; $display("[TB] FAIL reset_ctrl got=%h expected=0", ctrlRegs);
        end
        checks++;
        if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY} !== 3'b000) begin
            failures++; $display("[TB] FAIL reset_ready got=%b expected=000",
                {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY});
        end
        @(posedge clk); #1;
        checks++;
        if ({axi.S_AXI_BVALID, axi.S_AXI_RVALID, axi.S_AXI_BRESP, axi.S_AXI_RRESP, axi.S_AXI_RDATA,
             ctrlWrPulse, statusRdPulse} !== '0) begin
            failures++; $display("[TB] FAIL reset_resp got bv=%b rv=%b br=%b rr=%b rd=%h wp=%b rp=%b expected all 0",
                axi.S_AXI_BVALID, axi.S_AXI_RVALID, axi.S_AXI_BRESP, axi.S_AXI_RRESP,
                axi.S_AXI_RDATA, ctrlWrPulse, statusRdPulse);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY} !== 3'b111) begin
            failures++; $display("[TB] FAIL release_ready got=%b expected=111",
                {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY});
        end
    endtask

    task automatic test_basic_write_read();
        logic [1:0]  resp;
        logic [3:0]  pulse;
        logic [3:0]  pulseAfter;
        logic [31:0] data;
        bit          tmo;
        for (int i = 0; i < 3; i++) begin
            doWrite(32'(i * 4), 32'hDEADBEEF, 4'hF, resp, pulse, tmo);
            checks++;
            if (tmo || resp !== 2'b00 || pulse !== 4'(1 << i)) begin
                failures++; $display("[TB] FAIL basic_write%0d got tmo=%0d resp=%b pulse=%b expected tmo=0 resp=00 pulse=%b",
                    i, tmo, resp, pulse, 4'(1 << i));
            end
        end
        for (int i = 0; i < 3; i++) begin
            doRead(32'(i * 4), data, resp, pulse, pulseAfter, tmo);
            checks++;
            if (tmo || data !== 32'hDEADBEEF || resp !== 2'b00 || pulse !== 4'b0000) begin
                failures++; $display("[TB] FAIL basic_read%0d got tmo=%0d data=%h resp=%b rdpulse=%b expected DEADBEEF/00/0000",
                    i, tmo, data, resp, pulse);
            end
        end
        checks++;
        if (ctrlRegs !== {32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF}) begin
            failures++; $display("[TB] FAIL basic_ctrl got=%h", ctrlRegs);
        end
    endtask

    task automatic test_byte_strobes();
        logic [1:0]  resp;
        logic [3:0]  pulse;
        logic [3:0]  pulseAfter;
        logic [31:0] data;
        bit          tmo;
        doWrite(32'h4, 32'h12345678, 4'b0011, resp, pulse, tmo);
        doRead(32'h4, data, resp, pulse, pulseAfter, tmo);
        checks++;
        if (tmo || data !== 32'hDEAD5678 || resp !== 2'b00) begin
            failures++; $display("[TB] FAIL strobe_partial got tmo=%0d data=%h resp=%b expected DEAD5678/00", tmo, data, resp);
        end
        doWrite(32'hC, 32'hFFFFFFFF, 4'b0000, resp, pulse, tmo);
        checks++;
        if (tmo || resp !== 2'b00 || pulse !== 4'b1000 || ctrlRegs[3*DW +: DW] !== 32'h0) begin
            failures++; $display("[TB] FAIL strobe_zero got tmo=%0d resp=%b pulse=%b reg3=%h expected 00/1000/00000000",
                tmo, resp, pulse, ctrlRegs[3*DW +: DW]);
        end
        doRead(32'h6, data, resp, pulse, pulseAfter, tmo);
        checks++;
        if (tmo || data !== 32'hDEAD5678 || resp !== 2'b00) begin
            failures++; $display("[TB] FAIL unaligned_read got tmo=%0d data=%h resp=%b expected DEAD5678/00", tmo, data, resp);
        end
    endtask

    task automatic test_channel_order();
        // W three cycles ahead of AW, targeting register 3.
        axi.S_AXI_WDATA  = 32'hCAFE0001;
        axi.S_AXI_WSTRB  = 4'hF;
        axi.S_AXI_WVALID = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_WVALID = 1'b0;
        checks++;
        if (axi.S_AXI_WREADY !== 1'b0) begin
            failures++; $display("[TB] FAIL wfirst_wready got=%b expected=0", axi.S_AXI_WREADY);
        end
        repeat (2) @(posedge clk);
        #1;
        axi.S_AXI_AWADDR  = 32'hC;
        axi.S_AXI_AWVALID = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_AWVALID = 1'b0;
        checks++;
        if (axi.S_AXI_BVALID !== 1'b0) begin
            failures++; $display("[TB] FAIL wfirst_early got bvalid=%b expected=0", axi.S_AXI_BVALID);
        end
        @(posedge clk); #1;
        checks++;
        if ({axi.S_AXI_BVALID, axi.S_AXI_BRESP, ctrlWrPulse} !== {1'b1, 2'b00, 4'b1000}
            || ctrlRegs[3*DW +: DW] !== 32'hCAFE0001) begin
            failures++; $display("[TB] FAIL wfirst_commit got bv=%b br=%b pulse=%b reg3=%h expected 1/00/1000/CAFE0001",
                axi.S_AXI_BVALID, axi.S_AXI_BRESP, ctrlWrPulse, ctrlRegs[3*DW +: DW]);
        end
        axi.S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_BREADY = 1'b0;

        // AW ahead of W, targeting register 2.
        axi.S_AXI_AWADDR  = 32'h8;
        axi.S_AXI_AWVALID = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_AWVALID = 1'b0;
        checks++;
        if (axi.S_AXI_AWREADY !== 1'b0 || axi.S_AXI_BVALID !== 1'b0) begin
            failures++; $display("[TB] FAIL awfirst_hold got awready=%b bvalid=%b expected 0/0",
                axi.S_AXI_AWREADY, axi.S_AXI_BVALID);
        end
        repeat (2) @(posedge clk);
        #1;
        axi.S_AXI_WDATA  = 32'h0BADF00D;
        axi.S_AXI_WVALID = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_WVALID = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({axi.S_AXI_BVALID, axi.S_AXI_BRESP, ctrlWrPulse} !== {1'b1, 2'b00, 4'b0100}
            || ctrlRegs[2*DW +: DW] !== 32'h0BADF00D) begin
            failures++; $display("[TB] FAIL awfirst_commit got bv=%b br=%b pulse=%b reg2=%h expected 1/00/0100/0BADF00D",
                axi.S_AXI_BVALID, axi.S_AXI_BRESP, ctrlWrPulse, ctrlRegs[2*DW +: DW]);
        end
        axi.S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_BREADY = 1'b0;
    endtask

    task automatic test_illegal();
        logic [1:0]  resp;
        logic [3:0]  pulse;
        logic [3:0]  pulseAfter;
        logic [31:0] data;
        bit          tmo;
        logic [NRW*DW-1:0] expCtrl;
        expCtrl = {32'hCAFE0001, 32'h0BADF00D, 32'hDEAD5678, 32'hDEADBEEF};
        doWrite(32'h10, 32'h11111111, 4'hF, resp, pulse, tmo);
        checks++;
        if (tmo || resp !== 2'b10 || pulse !== 4'b0000 || ctrlRegs !== expCtrl) begin
            failures++; $display("[TB] FAIL wr_status got tmo=%0d resp=%b pulse=%b ctrl=%h expected 10/0000/%h",
                tmo, resp, pulse, ctrlRegs, expCtrl);
        end
        doWrite(32'h40, 32'h22222222, 4'hF, resp, pulse, tmo);
        checks++;
        if (tmo || resp !== 2'b10 || pulse !== 4'b0000 || ctrlRegs !== expCtrl) begin
            failures++; $display("[TB] FAIL wr_range got tmo=%0d resp=%b pulse=%b ctrl=%h expected 10/0000/%h",
                tmo, resp, pulse, ctrlRegs, expCtrl);
        end
        doRead(32'h40, data, resp, pulse, pulseAfter, tmo);
        checks++;
        if (tmo || data !== 32'h0 || resp !== 2'b10 || pulse !== 4'b0000) begin
            failures++; $display("[TB] FAIL rd_range got tmo=%0d data=%h resp=%b rdpulse=%b expected 0/10/0000",
                tmo, data, resp, pulse);
        end
        statusRegs[1*DW +: DW] = 32'h000000A5;
        doRead(32'h14, data, resp, pulse, pulseAfter, tmo);
        checks++;
        if (tmo || data !== 32'h000000A5 || resp !== 2'b00 || pulse !== 4'b0010 || pulseAfter !== 4'b0000) begin
            failures++; $display("[TB] FAIL rd_status1 got tmo=%0d data=%h resp=%b pulse=%b after=%b expected A5/00/0010/0000",
                tmo, data, resp, pulse, pulseAfter);
        end
    endtask

    task automatic test_back_pressure();
        bit ok;
        logic [31:0] held;
        axi.S_AXI_BREADY  = 1'b0;
        axi.S_AXI_AWADDR  = 32'h0;
        axi.S_AXI_WDATA   = 32'h00000001;
        axi.S_AXI_WSTRB   = 4'hF;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WVALID  = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_AWADDR = 32'h4;
        axi.S_AXI_WDATA  = 32'h22222222;
        @(posedge clk); #1;
        checks++;
        if (axi.S_AXI_BVALID !== 1'b1 || ctrlWrPulse !== 4'b0001 || axi.S_AXI_AWREADY !== 1'b1) begin
            failures++; $display("[TB] FAIL bp_first got bv=%b pulse=%b awready=%b expected 1/0001/1",
                axi.S_AXI_BVALID, ctrlWrPulse, axi.S_AXI_AWREADY);
        end
        @(posedge clk); #1;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        ok = (axi.S_AXI_AWREADY === 1'b0) && (axi.S_AXI_WREADY === 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            ok &= (axi.S_AXI_BVALID === 1'b1) && (ctrlWrPulse === 4'b0000)
                  && (ctrlRegs[1*DW +: DW] === 32'hDEAD5678);
        end
        checks++;
        if (!ok) begin
            failures++; $display("[TB] FAIL bp_stall got bv=%b pulse=%b reg1=%h expected held 1/0000/DEAD5678",
                axi.S_AXI_BVALID, ctrlWrPulse, ctrlRegs[1*DW +: DW]);
        end
        axi.S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (axi.S_AXI_BVALID !== 1'b0 || ctrlRegs[1*DW +: DW] !== 32'hDEAD5678) begin
            failures++; $display("[TB] FAIL bp_release got bv=%b reg1=%h expected 0/DEAD5678",
                axi.S_AXI_BVALID, ctrlRegs[1*DW +: DW]);
        end
        @(posedge clk); #1;
        checks++;
        if (axi.S_AXI_BVALID !== 1'b1 || ctrlWrPulse !== 4'b0010 || ctrlRegs[1*DW +: DW] !== 32'h22222222
            || ctrlRegs[0 +: DW] !== 32'h00000001) begin
            failures++; $display("[TB] FAIL bp_second got bv=%b pulse=%b reg1=%h reg0=%h expected 1/0010/22222222/00000001",
                axi.S_AXI_BVALID, ctrlWrPulse, ctrlRegs[1*DW +: DW], ctrlRegs[0 +: DW]);
        end
        @(posedge clk); #1;
        axi.S_AXI_BREADY = 1'b0;

        // Read side: status input changes while RVALID is stalled; RDATA must not follow it.
        statusRegs[2*DW +: DW] = 32'h00000077;
        axi.S_AXI_RREADY  = 1'b0;
        axi.S_AXI_ARADDR  = 32'h18;
        axi.S_AXI_ARVALID = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_ARVALID = 1'b0;
        statusRegs[2*DW +: DW] = 32'h00000088;
        held = axi.S_AXI_RDATA;
        ok = (held === 32'h00000077) && (statusRdPulse === 4'b0100);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            ok &= (axi.S_AXI_RVALID === 1'b1) && (axi.S_AXI_RDATA === 32'h00000077)
                  && (axi.S_AXI_ARREADY === 1'b0) && (statusRdPulse === 4'b0000);
        end
        checks++;
        if (!ok) begin
            failures++; $display("[TB] FAIL rd_stall got first=%h rv=%b rdata=%h expected held 00000077",
                held, axi.S_AXI_RVALID, axi.S_AXI_RDATA);
        end
        axi.S_AXI_RREADY = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_RREADY = 1'b0;
        checks++;
        if (axi.S_AXI_RVALID !== 1'b0) begin
            failures++; $display("[TB] FAIL rd_drain got rvalid=%b expected=0", axi.S_AXI_RVALID);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp;
        logic [3:0] pulse;
        bit         tmo;
        axi.S_AXI_AWADDR  = 32'h8;
        axi.S_AXI_AWVALID = 1'b1;
        @(posedge clk); #1;
        axi.S_AXI_AWVALID = 1'b0;
        checks++;
        if (axi.S_AXI_AWREADY !== 1'b0) begin
            failures++; $display("[TB] FAIL mid_aw_held got awready=%b expected=0", axi.S_AXI_AWREADY);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ctrlRegs !== '0 || {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY} !== 3'b000
            || axi.S_AXI_BVALID !== 1'b0 || axi.S_AXI_RVALID !== 1'b0 || axi.S_AXI_RDATA !== '0) begin
            failures++; $display("[TB] FAIL mid_reset got ctrl=%h ready=%b bv=%b rv=%b rdata=%h expected all 0",
                ctrlRegs, {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY},
                axi.S_AXI_BVALID, axi.S_AXI_RVALID, axi.S_AXI_RDATA);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        doWrite(32'h4, 32'h5A5A5A5A, 4'hF, resp, pulse, tmo);
        checks++;
        if (tmo || resp !== 2'b00 || pulse !== 4'b0010
            || ctrlRegs !== {32'h0, 32'h0, 32'h5A5A5A5A, 32'h0}) begin
            failures++; $display("[TB] FAIL mid_after got tmo=%0d resp=%b pulse=%b ctrl=%h expected 00/0010/reg1=5A5A5A5A only",
                tmo, resp, pulse, ctrlRegs);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        axi.S_AXI_AWADDR  = '0;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA   = '0;
        axi.S_AXI_WSTRB   = '0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_BREADY  = 1'b0;
        axi.S_AXI_ARADDR  = '0;
        axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY  = 1'b0;
        statusRegs        = '0;
        test_reset();
        test_basic_write_read();
        test_byte_strobes();
        test_channel_order();
        test_illegal();
        test_back_pressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/neuromorphic_axi_regfile.md
# neuromorphic_axi_regfile

Parametrised AXI4-Lite slave register file for the neuromorphic ASIC bridge. It replaces the fixed three-register host interface with configurable counts of read/write control registers and read-only status registers. Key features:
- Byte-strobe writes.
- Independent AW/W acceptance.
- SLVERR on illegal accesses.
- Per-register write and read-side-effect pulses.

It sits between the processor AXI interconnect and the network control/status logic (PWM drive, XADC capture, digit classifier).

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; legal values are 32 or 64.
- NUM_RW, 4, number of read/write control registers (1..16).
- NUM_RO, 4, number of read-only status registers (1..16).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  DATA_WIDTH  write data.
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- ctrl_regs  out  NUM_RW*DATA_WIDTH  flattened control registers; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ctrl_wr_pulse  out  NUM_RW  one-cycle pulse per committed write.
- status_regs  in  NUM_RO*DATA_WIDTH  flattened status inputs.
- status_rd_pulse  out  NUM_RO  one-cycle pulse per status read (used for clear-on-read upstream).

## Operation
- **Word index:** address >> log2(DATA_WIDTH/8); the low address bits are ignored.
  - Index 0..NUM_RW-1 selects a control register.
  - Index NUM_RW..NUM_RW+NUM_RO-1 selects a status register.
  - Any other index is out of range.
- **Write channel:** two holding flags, aw_full and w_full.
  - AWREADY = !aw_full && !rst.
  - WREADY = !w_full && !rst.
  - An AW handshake latches the address and sets aw_full. A W handshake latches data and strobe and sets w_full. AW and W may arrive in either order or in the same cycle.
  - Commit condition: aw_full && w_full && !BVALID. On the commit edge:
    - byte lanes with WSTRB=1 update the target control register;
    - both flags clear;
    - BVALID is set;
    - BRESP is set to 2'b00 for a control-register target, or 2'b10 (SLVERR) for a status or out-of-range target, with no state change.
  - ctrl_wr_pulse[i] is high for exactly the cycle after commit, and only on an OKAY write to register i. This holds even when WSTRB=0.
  - BVALID holds until BREADY; it clears on the edge where BVALID && BREADY.
- **Read channel:**
  - ARREADY = !RVALID && !rst.
  - On an AR handshake edge, RDATA/RRESP/RVALID are registered:
    - control register: current value, RRESP 2'b00;
    - status register: status_regs sampled at that edge, RRESP 2'b00;
    - out of range: data 0, RRESP 2'b10.
  - status_rd_pulse[j] is high for the single cycle after the handshake of a read to status register j.
  - RVALID and RDATA hold stable until RREADY.
- **Read/write ordering:** read and write channels are independent. If an AR handshake and a commit to the same control register occur on the same edge, the read returns the pre-write value.
- **Reset:** asserting rst at any time, including mid-transaction, drops all pending transactions immediately.
  - Values while rst is asserted: ctrl_regs all 0, flags 0, BVALID/RVALID 0, BRESP/RRESP 2'b00, RDATA 0, all pulses 0, all READY outputs 0.
  - The READY outputs rise combinationally after rst deasserts.

## Timing
- AW and W accepted together at edge N: commit at N+1; BVALID and ctrl_wr_pulse are high from N+1. The minimum write turnaround is two cycles.
- With BREADY already high, BVALID is a single cycle. Back-to-back writes sustain one write per two cycles.
- If BVALID is stalled and a second AW+W pair is held: AWREADY/WREADY stay low, and the second commit occurs on the edge after BVALID clears.
- Read: AR handshake at edge N; RVALID high from N. With RREADY held high, reads sustain one per two cycles.
- There are no combinational paths from AXI inputs to AXI outputs, apart from rst gating the READY outputs.

## Test plan
- **Basic write/read:** reset, then write 0xDEADBEEF to 0x0, 0x4 and 0x8 with AW and W presented together. Each gets BRESP 2'b00 and a ctrl_wr_pulse on bit 0/1/2. Reading back 0x0/0x4/0x8 returns 0xDEADBEEF with RRESP 2'b00.
- **Byte strobes:** register 1 = 0xDEADBEEF; write WDATA 0x12345678 with WSTRB 4'b0011 → register 1 reads 0xDEAD5678.
- **Channel order:** W presented 3 cycles before AW → WREADY drops after the W handshake, and the write commits the cycle after the AW handshake. Repeat with AW first and expect the same result.
- **Illegal accesses:** with NUM_RW=4 and NUM_RO=4:
  - write to 0x10 (status 0) → BRESP 2'b10, ctrl_regs unchanged;
  - read 0x40 → RDATA 0, RRESP 2'b10.
  - With status_regs[1]=0x000000A5, read 0x14 → 0xA5, and status_rd_pulse[1] is high for one cycle.
- **Back-pressure:** hold BREADY low for 5 cycles → BVALID stays high, and a second AW+W is accepted but not committed until after the first response clears. Likewise, hold RREADY low → RDATA stays stable.
- **Reset mid-transaction:** after an AW-only handshake, pulse rst → all outputs return to their reset values. A subsequent full write then behaves normally, with no stale address used.
